instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage between the PC and decode. Holds the program counter, drives the
//  combinational instruction memory address, and captures each returned byte
//  with its PC into a small queue. Presents {instr, pc} to decode over a
//  valid/ready handshake. Execute can redirect the fetch stream with a new PC.
// PARAMETERS
//  ADDR_W    8      PC / instruction-memory address width
//  INSTR_W   8      instruction width
//  QDEPTH    2      fetch-queue entries (power of 2, >=2)
//  RESET_PC  8'h00  PC value loaded at reset
// PORTS
//  clk             in   1        single clock, rising edge
//  rst_n           in   1        asynchronous, active-low reset
//  imem_addr       out  ADDR_W   address to instruction memory (= pc)
//  imem_instr      in   INSTR_W  combinational read data for imem_addr
//  redirect_valid  in   1        load redirect_pc this cycle (jump/branch taken)
//  redirect_pc     in   ADDR_W   new fetch address
//  out_valid       out  1        queue head valid toward decode
//  out_ready       in   1        decode accepts head
//  out_instr       out  INSTR_W  head instruction
//  out_pc          out  ADDR_W   address of head instruction
//  halted          out  1        only with FETCH_HALT_DETECT_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, queue empty, out_valid=0,
//    out_instr=0, out_pc=0, halted=0.
//  - imem_addr = pc (registered). push = !redirect_valid && !halted &&
//    (count<QDEPTH || pop). On push: enqueue {pc, imem_instr}; pc <= pc+1.
//  - pc wraps modulo 2^ADDR_W: 8'hFF -> 8'h00, no flag.
//  - pop = out_valid && out_ready. out_* = head entry. Head stays stable while
//    out_valid && !out_ready.
//  - Push and pop in the same cycle: count unchanged, allowed when full.
//  - Latency: byte fetched in cycle k is visible on out_* in cycle k+1 at the
//    earliest. Throughput is 1 instr/cycle with out_ready held high.
//  - Redirect has top priority. out_valid is forced 0 that cycle (no accept).
//    Queue flushed, no push, pc <= redirect_pc. Target instr on out at N+2.
//  - Empty queue: out_valid=0, out_instr/out_pc hold last values.
//  - Reset mid-operation: out_valid drops immediately. Queue contents are lost.
// CONFIGURATION
//  FETCH_HALT_DETECT_EN defined:
//  - A pushed instr with instr[7:5]==3'b110 (JMP) and {3'b0,instr[4:0]}==pc
//    is a self-jump.
//  - The self-jump is still enqueued. pc does not increment.
//  - halted <= 1 next edge. No further pushes until a redirect or reset.
//  - Redirect clears halted.
//  FETCH_HALT_DETECT_EN undefined: no halted port. Fetch continues
//  sequentially past every instruction. Execute is responsible for redirects.
// STRUCTURE
//  - cpu_pkg: ADDR_W/INSTR_W defaults, OP_JMP=3'b110, OP_JZ=3'b111, jump
//    target field [4:0], RESET_PC.
//  - Sub-module fetch_queue: parameterised FIFO of {pc,instr} with push, pop,
//    flush, count, full, empty.
//  - instr_fetch owns pc, push/redirect control and halt detect.
// TESTING (imem loaded with 40 51 29 20 25 E7 C6 C7 at 0..7)
//  1. Reset then out_ready=1 -> out emits (40,0),(51,1),(29,2),(20,3)... one per
//     cycle, first out_valid one cycle after reset release.
//  2. out_ready=0 from reset -> two pushes, pc stops at 2, imem_addr=2, out holds
//     (40,0). Raising out_ready resumes (51,1),(29,2) with no gap.
//  3. Queue holds 2 entries, redirect_valid=1 redirect_pc=7 -> out_valid=0 that
//     cycle. Next accepted head is (C7,7), two cycles after the redirect.
//  4. redirect_pc=8'hFF, out_ready=1 -> out emits (00,FF) then (40,00): wrap.
//  5. Macro on, run from 0 with redirects off -> (C6,6) enqueued, halted=1 next
//     cycle, pc stays 6. Redirect to 7 clears halted. Macro off -> pc goes to 7.
//  6. rst_n low while out_valid=1 -> out_valid=0 before next clk edge. After
//     release, pc=0 and the stream restarts from (40,0).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, reset PC and jump-opcode encoding.
package cpu_pkg;

    localparam int          ADDR_W   = 8;
    localparam int          INSTR_W  = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;

    // Opcode lives in instr[7:5]; jump target in instr[4:0].
    localparam logic [2:0]  OP_JMP   = 3'b110;
    localparam logic [2:0]  OP_JZ    = 3'b111;
    localparam int          OP_HI    = 7;
    localparam int          OP_LO    = 5;
    localparam int          TGT_HI   = 4;
    localparam int          TGT_LO   = 0;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} pairs between fetch and decode.
// Push and pop may coincide even when full; flush empties the queue.
module fetch_queue #(
    parameter int AW    = 8,
    parameter int IW    = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [AW-1:0]              push_pc_i,
    input  logic [IW-1:0]              push_instr_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [AW-1:0]              head_pc_o,
    output logic [IW-1:0]              head_instr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc_mem_q    [DEPTH];
    logic [IW-1:0] instr_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW:0]   count_q;

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                pc_mem_q[wr_ptr_q]    <= push_pc_i;
                instr_mem_q[wr_ptr_q] <= push_instr_i;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign full_o       = (count_q == (PW+1)'(DEPTH));
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives instruction-memory address, queues
// fetched {pc, instr} pairs toward decode, handles execute redirects.
// Optional self-jump halt detection is enabled by FETCH_HALT_DETECT_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = cpu_pkg::ADDR_W,
    parameter int              INSTR_W  = cpu_pkg::INSTR_W,
    parameter int              QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
`ifdef FETCH_HALT_DETECT_EN
    output logic               halted,
`endif
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  hold_pc_q;
    logic [INSTR_W-1:0] hold_instr_q;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [CW-1:0]      q_count;
    logic               q_full;
    logic               q_empty;
    logic               push;
    logic               pop;
    logic               stall_pc;

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q;
    logic self_jump;

    // A JMP whose 5-bit target equals its own address never leaves.
    assign self_jump = (imem_instr[OP_HI:OP_LO] == OP_JMP) &&
                       (ADDR_W'(imem_instr[TGT_HI:TGT_LO]) == pc_q);
    assign push      = !redirect_valid && !halted_q && (!q_full || pop);
    assign stall_pc  = self_jump;
    assign halted    = halted_q;

    // Halt latches on a pushed self-jump; only redirect or reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (push && self_jump) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign push     = !redirect_valid && (!q_full || pop);
    assign stall_pc = 1'b0;
`endif

    // Redirect hides the head so decode cannot accept a soon-to-be-flushed entry.
    assign out_valid = !q_empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign imem_addr = pc_q;

    fetch_queue #(
        .AW    (ADDR_W),
        .IW    (INSTR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_pc_i    (pc_q),
        .push_instr_i (imem_instr),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (q_count),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    // PC: redirect first, otherwise advance (mod 2^ADDR_W) on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (push && !stall_pc) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    // Remember the last presented head so outputs hold steady while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else if (q_count != '0) begin
            hold_pc_q    <= head_pc;
            hold_instr_q <= head_instr;
        end
    end

    assign out_instr = q_empty ? hold_instr_q : head_instr;
    assign out_pc    = q_empty ? hold_pc_q    : head_pc;

endmodule
